// File: rtl/ssd_pkg.sv
// Character codes, segment table, default message image and FSM states
// shared by the seven-segment message scroller and its character decoder.
package ssd_pkg;

    typedef logic [4:0] char_t;
    typedef logic [6:0] seg_t;

    localparam char_t CH_BLANK = 5'h00;
    localparam char_t CH_0     = 5'h01;
    localparam char_t CH_9     = 5'h0A;
    localparam char_t CH_H     = 5'h0B;
    localparam char_t CH_E     = 5'h0C;
    localparam char_t CH_L     = 5'h0D;
    localparam char_t CH_O     = 5'h0E;
    localparam char_t CH_D     = 5'h0F;
    localparam char_t CH_R     = 5'h10;
    localparam char_t CH_WL    = 5'h11;
    localparam char_t CH_WR    = 5'h12;
    localparam char_t CH_A     = 5'h13;
    localparam char_t CH_B     = 5'h14;
    localparam char_t CH_C     = 5'h15;
    localparam char_t CH_F     = 5'h16;
    localparam char_t CH_P     = 5'h17;
    localparam char_t CH_U     = 5'h18;
    localparam char_t CH_DASH  = 5'h19;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Indexed by char_t; bit 6 = a ... bit 0 = g, active-low. Codes 0x1A-0x1F are undefined.
    localparam seg_t SEG_TABLE [32] = '{
        7'b1111111, 7'b0000001, 7'b1001111, 7'b0010010,   // blank 0 1 2
        7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,   // 3 4 5 6
        7'b0001111, 7'b0000000, 7'b0000100, 7'b1001000,   // 7 8 9 H
        7'b0110000, 7'b1110001, 7'b0000001, 7'b1000010,   // E L O d
        7'b1111010, 7'b1100001, 7'b1000011, 7'b0001000,   // r WL WR A
        7'b1100000, 7'b0110001, 7'b0111000, 7'b0011000,   // b C F P
        7'b1000001, 7'b1111110, 7'b1111111, 7'b1111111,   // U dash
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    localparam int DEFAULT_LEN = 12;
    localparam char_t DEFAULT_MSG [DEFAULT_LEN] = '{
        CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK, CH_WL, CH_WR, CH_O, CH_R, CH_L, CH_D
    };

    typedef enum logic [1:0] {ST_RUN, ST_DWELL, ST_PAUSE} state_t;

    function automatic seg_t char_to_seg(input char_t c);
        return SEG_TABLE[c];
    endfunction

    function automatic char_t default_char(input int idx);
        if (idx < DEFAULT_LEN) return DEFAULT_MSG[idx];
        return CH_BLANK;
    endfunction

endpackage

// File: rtl/ssd_char_decoder.sv
// Maps a character code to its active-low a..g segment pattern; undefined codes are blank.
// Latency: purely combinational.
// Backpressure: none.
module ssd_char_decoder
    import ssd_pkg::*;
(
    input  char_t ch,
    output seg_t  seg
);
    assign seg = char_to_seg(ch);
endmodule

// File: rtl/ssd_message_scroller.sv
// Shows a NUM_DIGITS window of a writable message buffer, stepping by scroll or page; SSD_BLINK_EN blinks digits while paused.
// Latency: pos/step one edge after a tick; seg_out one edge after any pos or buffer change.
// Backpressure: none; pause freezes stepping, writes are always accepted.
module ssd_message_scroller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int MSG_LEN     = 16,
    parameter int TICK_DIV    = 50_000_000,
    parameter int DWELL_TICKS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic                       pause,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_char,
    output logic [7*NUM_DIGITS-1:0]    seg_out,
    output logic [$clog2(MSG_LEN)-1:0] pos,
    output logic                       step
);
    localparam int AW  = $clog2(MSG_LEN);
    localparam int CW  = $clog2(TICK_DIV);
    localparam int DWW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    char_t                   msg_q [MSG_LEN];
    state_t                  state_q, state_nxt;
    logic [AW-1:0]           pos_q, pos_nxt, adv_pos;
    logic [CW-1:0]           cnt_q, cnt_nxt, cnt_inc;
    logic [DWW-1:0]          dwell_q, dwell_nxt;
    logic                    step_q, step_nxt, tick;
    logic                    mode_q, mode_seen_q, mode_chg, blank_now;
    logic [7*NUM_DIGITS-1:0] seg_q;
    char_t                   dig_ch  [NUM_DIGITS];
    seg_t                    dig_seg [NUM_DIGITS];

    assign cnt_inc  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    assign tick     = (cnt_q == CNT_LAST) && (state_q != ST_PAUSE);
    // mode_seen_q stops the first cycle after reset from looking like a mode change
    assign mode_chg = mode_seen_q && (mode != mode_q);

    always_comb begin
        adv_pos = '0;
        if (mode) adv_pos = (int'(pos_q) + 1 >= MSG_LEN) ? '0 : pos_q + AW'(1);
        else      adv_pos = (int'(pos_q) + NUM_DIGITS >= MSG_LEN) ? '0 : AW'(int'(pos_q) + NUM_DIGITS);
    end

    always_comb begin
        state_nxt = state_q;
        pos_nxt   = pos_q;
        dwell_nxt = dwell_q;
        step_nxt  = 1'b0;
        cnt_nxt   = cnt_inc;
        case (state_q)
            ST_RUN: if (tick) begin
                pos_nxt  = adv_pos;
                step_nxt = (adv_pos != pos_q);
                if (adv_pos == '0 && DWELL_TICKS > 0) begin
                    state_nxt = ST_DWELL;
                    dwell_nxt = '0;
                end
            end
            ST_DWELL: if (tick) begin
                if (int'(dwell_q) >= DWELL_TICKS - 1) state_nxt = ST_RUN;
                else                                  dwell_nxt = dwell_q + DWW'(1);
            end
            ST_PAUSE: begin
                if (!pause) state_nxt = ST_RUN;
`ifdef SSD_BLINK_EN
                if (!pause) cnt_nxt = '0;
`else
                cnt_nxt = cnt_q;
`endif
            end
            default: state_nxt = ST_RUN;
        endcase
        if (pause) state_nxt = ST_PAUSE;
        if (mode_chg) begin
            state_nxt = ST_RUN;
            pos_nxt   = '0;
            cnt_nxt   = '0;
            dwell_nxt = '0;
            step_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pos_q       <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            step_q      <= 1'b0;
            mode_q      <= 1'b0;
            mode_seen_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            pos_q       <= pos_nxt;
            cnt_q       <= cnt_nxt;
            dwell_q     <= dwell_nxt;
            step_q      <= step_nxt;
            mode_q      <= mode;
            mode_seen_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= default_char(i);
        end else if (wr_en && int'(wr_addr) < MSG_LEN) begin
            msg_q[wr_addr] <= wr_char;
        end
    end

    // Scroll wraps past the buffer end; page shows blanks there instead
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [AW:0]   raw;
        logic [AW-1:0] idx;
        assign raw       = {1'b0, pos_q} + (AW+1)'(k);
        assign idx       = (raw >= (AW+1)'(MSG_LEN)) ? AW'(raw - (AW+1)'(MSG_LEN)) : raw[AW-1:0];
        assign dig_ch[k] = (mode || raw < (AW+1)'(MSG_LEN)) ? msg_q[idx] : CH_BLANK;
        ssd_char_decoder u_dec (.ch(dig_ch[k]), .seg(dig_seg[k]));
    end

`ifdef SSD_BLINK_EN
    logic blink_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             blink_q <= 1'b0;
        else if (state_nxt != ST_PAUSE)                         blink_q <= 1'b0;
        else if (state_q == ST_PAUSE && cnt_q == CNT_LAST)      blink_q <= ~blink_q;
    end
    assign blank_now = blink_q && (state_nxt == ST_PAUSE);
`else
    assign blank_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) seg_q[7*k +: 7] <= char_to_seg(default_char(k));
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) seg_q[7*k +: 7] <= blank_now ? SEG_BLANK : dig_seg[k];
        end
    end

    assign seg_out = seg_q;
    assign pos     = pos_q;
    assign step    = step_q;

endmodule

// File: tb/tb_ssd_message_scroller.sv
// Randomised bench for ssd_message_scroller with a behavioural reference model
// and a few hand-derived literal expectations.
module tb_ssd_message_scroller;
    localparam int ND = 6;
    localparam int ML = 12;
    localparam int TD = 4;
    localparam int DW = 2;
    localparam int AW = 4;

    localparam logic [7*ND-1:0] LIT_HELLO =
        {7'b1111111, 7'b0000001, 7'b1110001, 7'b1110001, 7'b0110000, 7'b1001000};
    localparam logic [7*ND-1:0] LIT_WORLD =
        {7'b1000010, 7'b1110001, 7'b1111010, 7'b0000001, 7'b1000011, 7'b1100001};
    localparam logic [7*ND-1:0] LIT_POS10 =
        {7'b1110001, 7'b1110001, 7'b0110000, 7'b1001000, 7'b1000010, 7'b1110001};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic            pause = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [4:0]      wr_char = '0;
    logic [7*ND-1:0] seg_out;
    logic [AW-1:0]   pos;
    logic            step;

    always #5 clk = ~clk;

    ssd_message_scroller #(
        .NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD), .DWELL_TICKS(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .pause(pause), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .seg_out(seg_out), .pos(pos), .step(step)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: message contents, window start, tick phase, and activity.
    logic [4:0]      m_buf [ML];
    int              m_pos, m_cnt, m_extra;
    bit              m_paused, m_dwelling, m_mode_prev, m_seen, m_step;
    logic [7*ND-1:0] m_seg;

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            1: return 7'b0000001;   2: return 7'b1001111;   3: return 7'b0010010;
            4: return 7'b0000110;   5: return 7'b1001100;   6: return 7'b0100100;
            7: return 7'b0100000;   8: return 7'b0001111;   9: return 7'b0000000;
            10: return 7'b0000100;  11: return 7'b1001000;  12: return 7'b0110000;
            13: return 7'b1110001;  14: return 7'b0000001;  15: return 7'b1000010;
            16: return 7'b1111010;  17: return 7'b1100001;  18: return 7'b1000011;
            19: return 7'b0001000;  20: return 7'b1100000;  21: return 7'b0110001;
            22: return 7'b0111000;  23: return 7'b0011000;  24: return 7'b1000001;
            25: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [4:0] hello(input int i);
        case (i)
            0: return 5'h0B; 1: return 5'h0C; 2: return 5'h0D; 3: return 5'h0D;
            4: return 5'h0E; 6: return 5'h11; 7: return 5'h12; 8: return 5'h0E;
            9: return 5'h10; 10: return 5'h0D; 11: return 5'h0F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] image(input int p, input bit scroll);
        logic [7*ND-1:0] img;
        int c;
        img = '0;
        for (int k = 0; k < ND; k++) begin
            if (p + k < ML)  c = int'(m_buf[p + k]);
            else if (scroll) c = int'(m_buf[p + k - ML]);
            else             c = 0;
            img[7*k +: 7] = seg_of(c);
        end
        return img;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ML; i++) m_buf[i] = hello(i);
        m_pos = 0; m_cnt = 0; m_extra = 0;
        m_paused = 0; m_dwelling = 0; m_mode_prev = 0; m_seen = 0; m_step = 0;
        m_seg = image(0, 1'b0);
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [7*ND-1:0] img;
        bit tick, changed;
        int nxt;
        img     = image(m_pos, mode);
        tick    = (m_cnt == TD - 1) && !m_paused;
        changed = m_seen && (mode != m_mode_prev);
        m_step  = 0;
        if (changed) begin
            m_pos = 0; m_cnt = 0; m_paused = 0; m_dwelling = 0;
        end else begin
            if (!m_paused) m_cnt = (m_cnt + 1) % TD;
            if (tick && !m_dwelling) begin
                nxt    = mode ? (m_pos + 1) % ML : ((m_pos + ND >= ML) ? 0 : m_pos + ND);
                m_step = (nxt != m_pos);
                m_pos  = nxt;
                if (m_pos == 0 && DW > 0) begin m_dwelling = 1; m_extra = 0; end
            end else if (tick && m_dwelling) begin
                m_extra++;
                if (m_extra == DW) m_dwelling = 0;
            end
            if (pause) m_paused = 1;
            else if (m_paused) begin m_paused = 0; m_dwelling = 0; end
            if (m_paused) m_dwelling = 0;
        end
        if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] = wr_char;
        m_mode_prev = mode;
        m_seen      = 1;
        m_seg       = img;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("pos", 64'(pos), 64'(m_pos));
        check("step", 64'(step), 64'(m_step));
        check("seg_out", 64'(seg_out), 64'(m_seg));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check("arst_seg", 64'(seg_out), 64'(LIT_HELLO));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [AW-1:0] held;
        logic [6:0] d0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare_all();
        check("rst_seg", 64'(seg_out), 64'(LIT_HELLO));
        check("rst_pos", 64'(pos), 64'd0);

        // Page mode: first tick after TICK_DIV edges moves to the second page.
        repeat (4) cycle();
        check("page_pos", 64'(pos), 64'd6);
        check("page_step", 64'(step), 64'd1);
        cycle();
        check("page_seg", 64'(seg_out), 64'(LIT_WORLD));

        // Switch to scroll, walk to pos 10 and check wrap-around display.
        mode = 1'b1;
        cycle();
        check("modechg_pos", 64'(pos), 64'd0);
        n = 0;
        while (pos != 10 && n < 200) begin cycle(); n++; end
        check("reach_pos10", 64'(pos), 64'd10);
        cycle();
        check("pos10_seg", 64'(seg_out), 64'(LIT_POS10));

        // Dwell: after the wrap to 0, the next step comes 3 tick periods later.
        n = 0;
        while (pos != 0 && n < 200) begin cycle(); n++; end
        check("wrap_to0", 64'(pos), 64'd0);
        n = 0;
        do begin cycle(); n++; end while (step != 1'b1 && n < 100);
        check("dwell_gap", 64'(n), 64'(TD * (1 + DW)));
        check("dwell_next", 64'(pos), 64'd1);

        // Mode toggle coincident with a tick: no step, prescaler restarts.
        repeat (3) cycle();
        mode = 1'b0;
        cycle();
        check("coinc_pos", 64'(pos), 64'd0);
        check("coinc_step", 64'(step), 64'd0);
        repeat (4) cycle();
        check("restart_pos", 64'(pos), 64'd6);

        // Writes: code 0x0A on digit 0 shows '9' two edges later; out-of-range ignored.
        mode = 1'b1;
        cycle();
        wr_en = 1'b1; wr_addr = 4'd0; wr_char = 5'h0A;
        cycle();
        wr_en = 1'b0;
        cycle();
        d0 = seg_out[6:0];
        check("write_digit0", 64'(d0), 64'(7'b0000100));
        wr_en = 1'b1; wr_addr = 4'd12; wr_char = 5'h19;
        cycle();
        wr_en = 1'b0;

        // Pause holds position.
        pause = 1'b1;
        cycle();
        held = pos;
        repeat (19) cycle();
        check("pause_hold", 64'(pos), 64'(held));
        pause = 1'b0;
        repeat (10) cycle();

        // Randomised traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            if ($urandom_range(59) == 0) mode = ~mode;
            if ($urandom_range(39) == 0) pause = ~pause;
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = AW'($urandom_range(15));
            wr_char = 5'($urandom_range(31));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
